// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter family.
//   MODE_WRAP / MODE_SAT : behaviour when a count crosses 0 or MAX_VAL
//   DIR_UP / DIR_DN      : encodings of the updown input
package counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage : counter_pkg

// File: rtl/updown_next_calc.sv
// Combinational next-count calculator for updown_counter_mod.
// Ports:
//   cntr    in   current (always legal, <= MAX_VAL) count
//   step    in   requested step; values above MAX_VAL are clamped to MAX_VAL
//   updown  in   DIR_UP / DIR_DN
//   mode    in   MODE_WRAP / MODE_SAT
//   nxt     out  next count
//   ovf_evt out  up-count crossed MAX_VAL
//   unf_evt out  down-count crossed 0
module updown_next_calc
    import counter_pkg::*;
#(
    parameter int                 WIDTH   = 4,
    parameter logic [WIDTH-1:0]   MAX_VAL = {WIDTH{1'b1}},
    parameter int                 STEP_W  = 2
) (
    input  logic [WIDTH-1:0]  cntr,
    input  logic [STEP_W-1:0] step,
    input  logic              updown,
    input  logic              mode,
    output logic [WIDTH-1:0]  nxt,
    output logic              ovf_evt,
    output logic              unf_evt
);

    // Modulus truncated to WIDTH bits; it is 0 for a full-range counter,
    // which still gives the right answer because the wrapped results are
    // formed modulo 2**WIDTH and always land in [0, MAX_VAL].
    localparam logic [WIDTH-1:0] MOD_W = MAX_VAL + 1'b1;

    logic [WIDTH-1:0] step_w;
    logic [WIDTH-1:0] s_eff;
    logic [WIDTH:0]   sum_ext;

    always_comb begin
        step_w  = WIDTH'(step);
        s_eff   = (step_w > MAX_VAL) ? MAX_VAL : step_w;
        // Overflow test needs the carry, so it is done one bit wider.
        sum_ext = {1'b0, cntr} + {1'b0, s_eff};

        nxt     = cntr;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;

        if (updown == DIR_UP) begin
            if (sum_ext > {1'b0, MAX_VAL}) begin
                ovf_evt = 1'b1;
                nxt     = (mode == MODE_SAT) ? MAX_VAL : (cntr + s_eff - MOD_W);
            end else begin
                nxt = cntr + s_eff;
            end
        end else begin
            if (s_eff > cntr) begin
                unf_evt = 1'b1;
                nxt     = (mode == MODE_SAT) ? '0 : (cntr + MOD_W - s_eff);
            end else begin
                nxt = cntr - s_eff;
            end
        end
    end

endmodule : updown_next_calc

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with programmable modulus, variable step,
// clamped parallel load and wrap/saturate mode.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset (highest priority)
//   en      in   count enable
//   load    in   parallel load strobe (beats en)
//   updown  in   1 = up, 0 = down
//   din     in   load value, clamped to MAX_VAL
//   step    in   step size, sampled each enabled cycle
//   cntr    out  registered count
//   at_max  out  cntr == MAX_VAL
//   at_min  out  cntr == 0
//   ovf     out  one-cycle pulse on up wrap/saturation
//   unf     out  one-cycle pulse on down wrap/saturation
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter int               STEP_W   = 2,
    parameter bit               SAT_MODE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic              updown,
    input  logic [WIDTH-1:0]  din,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  cntr,
    output logic              at_max,
    output logic              at_min,
    output logic              ovf,
    output logic              unf
);

    localparam logic MODE = SAT_MODE ? MODE_SAT : MODE_WRAP;

    logic [WIDTH-1:0] nxt;
    logic             ovf_evt;
    logic             unf_evt;

    updown_next_calc #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .STEP_W  (STEP_W)
    ) u_next_calc (
        .cntr    (cntr),
        .step    (step),
        .updown  (updown),
        .mode    (MODE),
        .nxt     (nxt),
        .ovf_evt (ovf_evt),
        .unf_evt (unf_evt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cntr <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else if (load) begin
            cntr <= (din > MAX_VAL) ? MAX_VAL : din;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else if (en) begin
            cntr <= nxt;
            ovf  <= ovf_evt;
            unf  <= unf_evt;
        end else begin
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end
    end

    assign at_max = (cntr == MAX_VAL);
    assign at_min = (cntr == '0);

endmodule : updown_counter_mod
